// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if
// Groups the requester handshake and the APB3 bus driven by apb_master_arbiter.
//   Requester side : REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA (in to arbiter),
//                    DONE, RDATA, ERR, TMO (out from arbiter)
//   APB side       : PADDR, PSEL, PENABLE, PWRITE, PWDATA (out from arbiter),
//                    PRDATA, PREADY, PSLVERR (in to arbiter)
// NUM_REQ must match the NUM_REQ of the arbiter the interface is bound to.
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    REQ;
    logic [NUM_REQ-1:0]    REQ_WRITE;
    logic [32*NUM_REQ-1:0] REQ_ADDR;
    logic [32*NUM_REQ-1:0] REQ_WDATA;
    logic [NUM_REQ-1:0]    DONE;
    logic [31:0]           RDATA;
    logic                  ERR;
    logic                  TMO;

    logic [31:0]           PADDR;
    logic [15:0]           PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // Arbiter side
    modport master (
        input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
        output DONE, RDATA, ERR, TMO, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    // Requesters plus APB slave side
    modport slave (
        output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
        input  DONE, RDATA, ERR, TMO, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Round-robin arbiter in front of an APB3 master sequencer. Up to eight
// requesters hold REQ until a one-cycle DONE pulse; the granted request is
// run as SETUP/ACCESS on the APB bus, with a PREADY wait-state timeout.
// Ports:
//   PCLK    clock
//   PRESET  asynchronous active-high reset
//   bus     apb_master_arbiter_if.master (requester handshake + APB bus)
// Parameters:
//   NUM_REQ 1..8       number of requesters
//   TIMEOUT 1..65535   ACCESS cycles with PREADY low tolerated before abort
module apb_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input logic                  PCLK,
    input logic                  PRESET,
    apb_master_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state;
    logic [2:0]           last_grant;
    logic [2:0]           grant;
    logic [15:0]          wait_cnt;

    logic [NUM_REQ-1:0]   done_q;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic                 tmo_q;
    logic [31:0]          paddr_q;
    logic [15:0]          psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [31:0]          pwdata_q;

    // Requester inputs padded to a fixed 8-entry view so the grant index
    // never selects outside the real vectors.
    logic [7:0]           eligible;
    logic [7:0]           req_write8;
    logic [31:0]          req_addr  [8];
    logic [31:0]          req_wdata [8];

    logic                 grant_valid;
    logic [2:0]           grant_next;
    logic [3:0]           cand;

    function automatic logic [NUM_REQ-1:0] grant_onehot(input logic [2:0] g);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r[i] = (3'(i) == g);
        end
        return r;
    endfunction

    for (genvar i = 0; i < 8; i++) begin : g_pad
        if (i < NUM_REQ) begin : g_used
            // A requester in its own DONE cycle still shows the old REQ;
            // masking it stops a stale regrant.
            assign eligible[i]   = bus.REQ[i] & ~done_q[i];
            assign req_write8[i] = bus.REQ_WRITE[i];
            assign req_addr[i]   = bus.REQ_ADDR[32*i +: 32];
            assign req_wdata[i]  = bus.REQ_WDATA[32*i +: 32];
        end else begin : g_unused
            assign eligible[i]   = 1'b0;
            assign req_write8[i] = 1'b0;
            assign req_addr[i]   = '0;
            assign req_wdata[i]  = '0;
        end
    end

    // Search upward from last_grant+1, wrapping at NUM_REQ. last_grant is
    // always below NUM_REQ, so one conditional subtraction wraps the sum.
    always_comb begin
        grant_valid = 1'b0;
        grant_next  = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!grant_valid && eligible[cand[2:0]]) begin
                grant_valid = 1'b1;
                grant_next  = cand[2:0];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= 3'(NUM_REQ - 1);
            grant      <= '0;
            wait_cnt   <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            paddr_q    <= '0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant    <= grant_next;
                        paddr_q  <= req_addr[grant_next];
                        pwrite_q <= req_write8[grant_next];
                        pwdata_q <= req_wdata[grant_next];
                        psel_q   <= 16'h0001 << req_addr[grant_next][27:24];
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so a ready slave in the same
                    // cycle the count expires completes normally.
                    if (bus.PREADY || (wait_cnt == 16'(TIMEOUT))) begin
                        psel_q     <= '0;
                        penable_q  <= 1'b0;
                        done_q     <= grant_onehot(grant);
                        last_grant <= grant;
                        state      <= IDLE;
                        if (bus.PREADY) begin
                            rdata_q <= pwrite_q ? 32'h0 : bus.PRDATA;
                            err_q   <= bus.PSLVERR;
                            tmo_q   <= 1'b0;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            tmo_q   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DONE    = done_q;
    assign bus.RDATA   = rdata_q;
    assign bus.ERR     = err_q;
    assign bus.TMO     = tmo_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;

endmodule
